// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and helpers for the 16-way bus arbiter
package arb_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;
    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_TURN = 2'd2;

    // Decode an owner index into its one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// rtl/rr_pick16.sv - combinational round-robin picker, search starts after ptr
module rr_pick16
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0]     start;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     off;

    // Rotate so the requester just after the last owner lands at bit 0.
    assign start = ptr + SEL_W'(1);
    assign dbl   = {req, req};
    assign rot   = dbl[start +: NUM_REQ];

    // Lowest set bit of the rotated vector is the nearest requester in ring order.
    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    // Un-rotate: the 4-bit add wraps naturally modulo 16.
    assign idx   = start + off;
    assign found = |req;

endmodule

// File: rtl/bus_arbiter_16.sv
// rtl/bus_arbiter_16.sv - round-robin owner/select generator for a 16:1 shared bus
module bus_arbiter_16
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    output logic [SEL_W-1:0]     select,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 bus_valid,
    output logic                 preempt
);

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   ptr_nxt;
    logic [7:0]         hold_cnt;
    logic [7:0]         hold_nxt;
    logic [SEL_W-1:0]   select_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic               preempt_nxt;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               owner_req;
    logic               hold_last;

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_req = req[select];
    assign hold_last = (hold_cnt == 8'(MAX_HOLD - 1));

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE and TURN both arbitrate; BUSY leaves on release or hold expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_TURN: state_nxt = pick_found ? ST_BUSY : ST_IDLE;
            ST_BUSY:          if (!owner_req || hold_last) state_nxt = ST_TURN;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs, pointer and hold counter.
    always_comb begin
        select_nxt  = select;
        grant_nxt   = grant;
        preempt_nxt = 1'b0;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        case (state)
            ST_IDLE, ST_TURN: begin
                grant_nxt = '0;
                if (pick_found) begin
                    select_nxt = pick_idx;
                    grant_nxt  = onehot16(pick_idx);
                    ptr_nxt    = pick_idx;
                    hold_nxt   = '0;
                end
            end
            ST_BUSY: begin
                hold_nxt = hold_cnt + 8'd1;
                if (!owner_req || hold_last) begin
                    grant_nxt   = '0;
                    // Only a forced hand-over (owner still asking) is flagged.
                    preempt_nxt = owner_req;
                end
            end
            default: begin
                grant_nxt = '0;
            end
        endcase
    end

    // Output, pointer and counter registers; ptr resets to 15 so the first search starts at 0.
    always_ff @(posedge clock) begin
        if (!reset) begin
            select   <= '0;
            grant    <= '0;
            preempt  <= 1'b0;
            ptr      <= SEL_W'(NUM_REQ - 1);
            hold_cnt <= '0;
        end else begin
            select   <= select_nxt;
            grant    <= grant_nxt;
            preempt  <= preempt_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    assign bus_valid = (|grant) & owner_req;

endmodule
